// File: rtl/logic_arb_pkg.sv
// Shared definitions for the logic-unit arbiter: op encodings, FSM states
// and the width of the optional per-requester grant counters.
package logic_arb_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

    localparam int          CNT_W   = 16;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/logic_unit_arbiter_op.sv
// Combinational WIDTH-bit bitwise logic unit (AND / OR / XOR / NOT a).
// Each branch is a plain bitwise operator so synthesis maps it onto the
// W_AND32 / W_OR32 / W_XOR gate cells of the datapath library.
module logic_unit_op
    import logic_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Select the requested function; b is ignored for NOT.
    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOT:  y = ~a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic unit between NREQ requesters.
// Handshake: a transfer happens on any rising edge where valid & ready are
// both high; valid never depends on ready, ready may depend on valid.
// One op is in flight: HOLD owns the response register until rsp_ready.
// Optional feature: define LOGIC_ARB_STATS_EN to add grant_cnt, a
// saturating 16-bit accepted-request counter per requester.
module logic_unit_arbiter
    import logic_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = 32,
    parameter int IDW   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [2*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data
`ifdef LOGIC_ARB_STATS_EN
    ,
    output logic [CNT_W*NREQ-1:0] grant_cnt
`endif
);

    arb_state_e       state_q, state_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;

    logic             can_accept;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic             accept;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b, op_result;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    // Scanning from the far end lets the nearest candidate win last.
    function automatic logic [IDW:0] pick(input logic [NREQ-1:0] v,
                                          input logic [IDW-1:0]  ptr);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (v[idx]) res = {1'b1, IDW'(idx)};
        end
        return res;
    endfunction

    // Grant selection, ready generation and operand steering.
    always_comb begin
        can_accept  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && rsp_ready);
        {grant_found, grant_idx} = pick(req_valid, rr_ptr_q);
        req_ready = '0;
        if (grant_found && can_accept && !rst) req_ready[grant_idx] = 1'b1;
        accept = grant_found && can_accept;
        sel_op = req_op[int'(grant_idx)*2 +: 2];
        sel_a  = req_a[int'(grant_idx)*WIDTH +: WIDTH];
        sel_b  = req_b[int'(grant_idx)*WIDTH +: WIDTH];
    end

    logic_unit_op #(.WIDTH(WIDTH)) u_op (
        .op (sel_op),
        .a  (sel_a),
        .b  (sel_b),
        .y  (op_result)
    );

    // Next-state: retire on rsp_ready, then a same-edge accept overrides.
    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rr_ptr_d    = rr_ptr_q;
        if (state_q == ST_HOLD && rsp_ready) begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
        end
        if (accept) begin
            state_d     = ST_HOLD;
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_idx;
            rsp_data_d  = op_result;
            rr_ptr_d    = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    // FSM, response register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

`ifdef LOGIC_ARB_STATS_EN
    logic [CNT_W*NREQ-1:0] grant_cnt_q, grant_cnt_d;

    // Saturating increment of the granted requester's counter.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if (accept && grant_cnt_q[int'(grant_idx)*CNT_W +: CNT_W] != CNT_MAX)
            grant_cnt_d[int'(grant_idx)*CNT_W +: CNT_W] =
                grant_cnt_q[int'(grant_idx)*CNT_W +: CNT_W] + 1'b1;
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) grant_cnt_q <= '0;
        else     grant_cnt_q <= grant_cnt_d;
    end

    assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed + random bench for logic_unit_arbiter against a transaction-level
// reference model (pending response slot, round-robin pointer, counters).
module tb_logic_unit_arbiter;

  localparam int NREQ  = 2;
  localparam int WIDTH = 32;
  localparam int IDW   = 3;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
`ifdef LOGIC_ARB_STATS_EN
  logic [16*NREQ-1:0]    grant_cnt;
`endif

  logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
`ifdef LOGIC_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit          m_valid;
  int          m_id;
  logic [31:0] m_data;
  int          m_rr;
  int          m_cnt[NREQ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // Requester the model would grant this cycle, or -1.
  function automatic int ref_grant(input logic [NREQ-1:0] v, input logic rr);
    if (m_valid && !rr) return -1;
    for (int k = 0; k < NREQ; k++)
      if (v[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_data = '0; m_rr = 0;
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
  endtask

  // One cycle: drive, check before the edge, advance model at the edge.
  task automatic step(input logic [NREQ-1:0] v, input logic [2*NREQ-1:0] op,
                      input logic [WIDTH*NREQ-1:0] a, input logic [WIDTH*NREQ-1:0] b,
                      input logic rr);
    int g;
    logic [NREQ-1:0] exp_ready;
    req_valid = v; req_op = op; req_a = a; req_b = b; rsp_ready = rr;
    g = ref_grant(v, rr);
    exp_ready = '0;
    if (g >= 0 && !rst) exp_ready[g] = 1'b1;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("rsp_id",    32'(rsp_id),    32'(m_id));
    chk("rsp_data",  rsp_data,       m_data);
`ifdef LOGIC_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++)
      chk("grant_cnt", 32'(grant_cnt[i*16 +: 16]), 32'(m_cnt[i]));
`endif
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (g >= 0) begin
      m_data  = ref_op(op[2*g +: 2], a[WIDTH*g +: WIDTH], b[WIDTH*g +: WIDTH]);
      m_id    = g;
      m_valid = 1;
      m_rr    = (g + 1) % NREQ;
      if (m_cnt[g] < 65535) m_cnt[g]++;
    end else if (m_valid && rr) begin
      m_valid = 0;
    end
    #1;
  endtask

  logic [WIDTH*NREQ-1:0] ra, rb;

  initial begin
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    model_reset();

    // reset with a request pending: nothing may be accepted
    rst = 1'b1;
    @(posedge clk); #1;
    step(2'b11, '0, '0, '0, 1'b1);
    step(2'b11, '0, '0, '0, 1'b1);
    rst = 1'b0;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_data", rsp_data, 32'h0);

    // single AND on requester 0
    step(2'b01, 4'b0000, {32'h0, 32'hFFFFFFFF}, {32'h0, 32'h0000FFFF}, 1'b1);
    chk("and_valid", 32'(rsp_valid), 32'h1);
    chk("and_id", 32'(rsp_id), 32'h0);
    chk("and_data", rsp_data, 32'h0000FFFF);

    // OR / XOR / NOT on requester 1, one result per cycle
    step(2'b10, 4'b0100, {32'hF0F0F0F0, 32'h0}, {32'hFF00FF00, 32'h0}, 1'b1);
    chk("or_data", rsp_data, 32'hFFF0FFF0);
    step(2'b10, 4'b1000, {32'hF0F0F0F0, 32'h0}, {32'hFF00FF00, 32'h0}, 1'b1);
    chk("xor_data", rsp_data, 32'h0FF00FF0);
    step(2'b10, 4'b1100, {32'hF0F0F0F0, 32'h0}, {32'hFF00FF00, 32'h0}, 1'b1);
    chk("not_data", rsp_data, 32'h0F0F0F0F);
    chk("not_id", 32'(rsp_id), 32'h1);
    step(2'b00, '0, '0, '0, 1'b1);
    chk("drain_valid", 32'(rsp_valid), 32'h0);

    // both requesters continuously valid: ids alternate 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      step(2'b11, 4'b0101, {32'h12345678, 32'h9ABCDEF0}, {32'h0F0F0F0F, 32'hFFFF0000}, 1'b1);
      chk("rr_id", 32'(rsp_id), 32'(i % 2));
    end

    // backpressure: response held, operands changing underneath
    step(2'b11, 4'b0110, {32'hAAAA5555, 32'h13572468}, {32'h0000FFFF, 32'hFFFF0000}, 1'b1);
    chk("bp_first_id", 32'(rsp_id), 32'h0);
    chk("bp_first_data", rsp_data, 32'hECA82468);
    for (int i = 0; i < 5; i++) begin
      step(2'b11, 4'b1111, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      chk("bp_hold_id", 32'(rsp_id), 32'h0);
      chk("bp_hold_data", rsp_data, 32'hECA82468);
    end
    step(2'b11, 4'b0000, {32'hFFFFFFFF, 32'h0}, {32'h00FF00FF, 32'h0}, 1'b1);
    chk("bp_release_id", 32'(rsp_id), 32'h1);
    chk("bp_release_data", rsp_data, 32'h00FF00FF);

    // reset while a response is pending
    step(2'b11, 4'b0000, {32'h1, 32'h3}, {32'h1, 32'h3}, 1'b0);
    rst = 1'b1;
    step(2'b11, 4'b0000, '0, '0, 1'b0);
    rst = 1'b0;
    chk("midrst_valid", 32'(rsp_valid), 32'h0);
    step(2'b11, 4'b0010, {32'h0, 32'h0000000F}, {32'h0, 32'h000000F0}, 1'b1);
    chk("midrst_ptr_id", 32'(rsp_id), 32'h0);
    step(2'b00, '0, '0, '0, 1'b1);
    step(2'b10, 4'b0100, {32'h000000F0, 32'h0}, {32'h0000000F, 32'h0}, 1'b1);
    chk("midrst_req1_id", 32'(rsp_id), 32'h1);
    chk("midrst_req1_data", rsp_data, 32'h000000FF);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rst = ($urandom_range(0, 63) == 0);
      step(NREQ'($urandom_range(0, 3)), 4'($urandom), ra, rb, 1'($urandom_range(0, 3) != 0));
    end
    rst = 1'b0;

`ifdef LOGIC_ARB_STATS_EN
    rst = 1'b1;
    step('0, '0, '0, '0, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(2'b11, '0, '0, '0, 1'b1);
    step(2'b01, '0, '0, '0, 1'b1);
    step('0, '0, '0, '0, 1'b1);
    chk("cnt0_three", 32'(grant_cnt[15:0]), 32'd3);
    chk("cnt1_two", 32'(grant_cnt[31:16]), 32'd2);
    for (int i = 0; i < 65535; i++) step(2'b01, '0, '0, '0, 1'b1);
    step('0, '0, '0, '0, 1'b1);
    chk("cnt0_saturate", 32'(grant_cnt[15:0]), 32'hFFFF);
    chk("cnt1_unchanged", 32'(grant_cnt[31:16]), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOT, built from the W_AND32/W_OR32/W_XOR gate cells) between NREQ requesters.
- Round-robin arbitration, valid/ready handshake on each request port and on the single response port, one operation in flight.
- Sits between the decode/issue stages and the gate-level logic datapath.

Parameters:
- NREQ, 2, number of requesters (2..8).
- WIDTH, 32, operand/result width.
- IDW, 3, response ID width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept (at most one bit set per cycle)
- req_op  input  2*NREQ  op for requester i in bits [2i+1:2i]: 00 AND, 01 OR, 10 XOR, 11 NOT a
- req_a  input  WIDTH*NREQ  operand A, requester i in slice i
- req_b  input  WIDTH*NREQ  operand B (ignored for NOT)
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  IDW  index of the requester that owns the result
- rsp_data  output  WIDTH  registered result

Behaviour:
- Interface is fixed: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, rr_ptr=0; req_ready=0 during reset cycle.
- FSM states: IDLE, HOLD.
- can_accept = (state==IDLE) | (state==HOLD & rsp_ready).
- Grant: first i with req_valid[i]=1, searching from rr_ptr upward modulo NREQ; req_ready[i]=can_accept & grant[i]. req_ready is combinational from req_valid, state and rsp_ready; req_valid must not depend on req_ready.
- Handshake on request i: req_valid[i] & req_ready[i]. On that edge: rsp_data <= op result, rsp_id <= i, rsp_valid <= 1, state <= HOLD, rr_ptr <= (i+1) mod NREQ.
- Latency: result visible exactly one cycle after request acceptance.
- HOLD with rsp_ready=1 and no request: rsp_valid <= 0, state <= IDLE.
- HOLD with rsp_ready=1 and a request: response retires and the new request is accepted on the same edge. Back-to-back throughput is 1 op/cycle.
- HOLD with rsp_ready=0: rsp_data/rsp_id/rsp_valid held stable and all req_ready=0.
- No request: rr_ptr unchanged.
- Operands/op sampled only on the accepting edge; later changes are ignored.
- Unused op encodings: none; all four are defined.
- Reset mid-operation: pending response discarded, rsp_valid=0 next cycle, no retire.

Optional Feature:
- Macro: LOGIC_ARB_STATS_EN.
- Defined: adds output grant_cnt (16*NREQ). Per-requester 16-bit counter increments on each accepted request and saturates at 16'hFFFF. Counters clear on rst.
- Undefined: port and counters absent; all other behaviour identical.

Decomposition:
- Shared package logic_arb_pkg: op encoding constants (OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOT=2'b11) and state encoding (ST_IDLE, ST_HOLD).
- One sub-module, logic_unit_op: combinational WIDTH-bit unit selecting AND/OR/XOR/NOT from op, built on the gate cells.
- Arbiter, FSM and response register stay in the top module.

Test Plan:
- Reset, then single request: req0 valid, op=AND, a=32'hFFFFFFFF, b=32'h0000FFFF -> req_ready[0]=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=32'h0000FFFF.
- All ops on requester 1 with a=32'hF0F0F0F0, b=32'hFF00FF00, rsp_ready held 1 -> OR=FFF0FFF0, XOR=0FF00FF0, NOT=0F0F0F0F, one result per cycle.
- Both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1.
- Backpressure: rsp_ready=0 for 5 cycles after first accept -> rsp_data/rsp_id stable, req_ready=0. When rsp_ready=1, the next request is accepted on that same edge.
- Assert rst while rsp_valid=1 -> next cycle rsp_valid=0, rr_ptr=0. A subsequent request from requester 1 alone is still granted.
- With LOGIC_ARB_STATS_EN: 3 grants to req0 and 2 to req1 -> grant_cnt slice0=3, slice1=2. Preloading slice0 to 16'hFFFF and granting again -> stays 16'hFFFF.
